pipe_ctrl: RTL and testbench

Pipeline control unit for the three-stage RISC-V core (fetch / decode / execute). It sequences the `pc_reg`, `if_id` and `id_ex` stages. It does this by generating hold, flush and PC-redirect controls from four sources:
- execute-stage jumps/branches
- multi-cycle execute busy requests
- load-use hazards detected at decode
- an external halt/resume handshake for debug

It also keeps a free-running stall-cycle counter for performance monitoring.

---
 rtl/pipe_ctrl.sv | 117 +++++++++++
 tb/tb_pipe_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hold/flush/redirect control for the 3-stage core
// Arbitrates jump, ex-busy, debug halt and load-use hazards; counts stall cycles.
module pipe_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        ex_busy_i,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic [4:0]  id_ex_rd_addr_i,
    input  logic        id_ex_load_i,
    input  logic        halt_req_i,
    output logic        pc_hold_o,
    output logic        pc_jump_en_o,
    output logic [31:0] pc_jump_addr_o,
    output logic        if_id_hold_o,
    output logic        if_id_flush_o,
    output logic        id_ex_hold_o,
    output logic        id_ex_flush_o,
    output logic        halt_ack_o,
    output logic [31:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    state_t      state;
    logic [3:0]  drain_cnt;
    logic [31:0] stall_cnt_q;
    logic        load_use;
    logic        halt_term;

    assign stall_cnt_o = stall_cnt_q;

    // A fresh halt request is honoured combinationally so pc/if_id freeze
    // in the very first request cycle, before the FSM has left RUN.
    always_comb begin
        load_use       = id_ex_load_i && (id_ex_rd_addr_i != 5'd0) &&
                         ((id_ex_rd_addr_i == id_rs1_addr_i) ||
                          (id_ex_rd_addr_i == id_rs2_addr_i));
        halt_term      = (state != ST_RUN) || halt_req_i;
        pc_jump_addr_o = jump_addr_i;
        pc_hold_o      = 1'b0;
        pc_jump_en_o   = 1'b0;
        if_id_hold_o   = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_hold_o   = 1'b0;
        id_ex_flush_o  = 1'b0;
        if (jump_en_i) begin
            pc_jump_en_o  = 1'b1;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (ex_busy_i) begin
            pc_hold_o    = 1'b1;
            if_id_hold_o = 1'b1;
            id_ex_hold_o = 1'b1;
        end else if (halt_term || load_use) begin
            pc_hold_o     = 1'b1;
            if_id_hold_o  = 1'b1;
            id_ex_flush_o = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            drain_cnt   <= 4'd0;
            halt_ack_o  <= 1'b0;
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_q + {31'd0, pc_hold_o};
            case (state)
                ST_RUN: begin
                    if (halt_req_i) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    // Busy cycles freeze the drain count; a jump does not.
                    if (!halt_req_i) begin
                        state     <= ST_RUN;
                        drain_cnt <= 4'd0;
                    end else if (!ex_busy_i) begin
                        if (drain_cnt == 4'd1) begin
                            state      <= ST_HALTED;
                            halt_ack_o <= 1'b1;
                            drain_cnt  <= 4'd0;
                        end else begin
                            drain_cnt <= drain_cnt - 4'd1;
                        end
                    end
                end
                ST_HALTED: begin
                    if (!halt_req_i) begin
                        state      <= ST_RUN;
                        halt_ack_o <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_RUN;
                    halt_ack_o <= 1'b0;
                    drain_cnt  <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

    localparam int DRAIN = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        ex_busy_i;
    logic [4:0]  id_rs1_addr_i;
    logic [4:0]  id_rs2_addr_i;
    logic [4:0]  id_ex_rd_addr_i;
    logic        id_ex_load_i;
    logic        halt_req_i;
    logic        pc_hold_o;
    logic        pc_jump_en_o;
    logic [31:0] pc_jump_addr_o;
    logic        if_id_hold_o;
    logic        if_id_flush_o;
    logic        id_ex_hold_o;
    logic        id_ex_flush_o;
    logic        halt_ack_o;
    logic [31:0] stall_cnt_o;

    pipe_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst(rst),
        .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i), .ex_busy_i(ex_busy_i),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_ex_rd_addr_i(id_ex_rd_addr_i), .id_ex_load_i(id_ex_load_i),
        .halt_req_i(halt_req_i),
        .pc_hold_o(pc_hold_o), .pc_jump_en_o(pc_jump_en_o), .pc_jump_addr_o(pc_jump_addr_o),
        .if_id_hold_o(if_id_hold_o), .if_id_flush_o(if_id_flush_o),
        .id_ex_hold_o(id_ex_hold_o), .id_ex_flush_o(id_ex_flush_o),
        .halt_ack_o(halt_ack_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: halted flag, drain cycles still owed, stall count.
    bit          m_halted = 1'b0;
    int          m_drain_left = 0;
    logic [31:0] m_stall = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        bit lu, halting, stall_src;
        @(negedge clk);
        lu = id_ex_load_i && id_ex_rd_addr_i != 0 &&
             (id_ex_rd_addr_i == id_rs1_addr_i || id_ex_rd_addr_i == id_rs2_addr_i);
        halting = m_halted || (m_drain_left > 0) || halt_req_i;
        stall_src = ex_busy_i || halting || lu;
        chk("pc_jump_en", 32'(pc_jump_en_o), 32'(jump_en_i));
        chk("pc_jump_addr", pc_jump_addr_o, jump_addr_i);
        chk("if_id_flush", 32'(if_id_flush_o), 32'(jump_en_i));
        chk("id_ex_flush", 32'(id_ex_flush_o), 32'(jump_en_i || (!ex_busy_i && (halting || lu))));
        chk("pc_hold", 32'(pc_hold_o), 32'(!jump_en_i && stall_src));
        chk("if_id_hold", 32'(if_id_hold_o), 32'(!jump_en_i && stall_src));
        chk("id_ex_hold", 32'(id_ex_hold_o), 32'(!jump_en_i && ex_busy_i));
        chk("halt_ack", 32'(halt_ack_o), 32'(m_halted));
        chk("stall_cnt", stall_cnt_o, m_stall);
    endtask

    task automatic advance();
        bit lu, hold;
        lu = id_ex_load_i && id_ex_rd_addr_i != 0 &&
             (id_ex_rd_addr_i == id_rs1_addr_i || id_ex_rd_addr_i == id_rs2_addr_i);
        hold = !jump_en_i && (ex_busy_i || m_halted || m_drain_left > 0 || halt_req_i || lu);
        if (rst) begin
            m_halted = 1'b0;
            m_drain_left = 0;
            m_stall = 32'd0;
        end else begin
            if (hold) m_stall = m_stall + 32'd1;
            if (m_halted) begin
                if (!halt_req_i) m_halted = 1'b0;
            end else if (m_drain_left > 0) begin
                if (!halt_req_i) m_drain_left = 0;
                else if (!ex_busy_i) begin
                    m_drain_left--;
                    if (m_drain_left == 0) m_halted = 1'b1;
                end
            end else if (halt_req_i) begin
                m_drain_left = DRAIN;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; jump_en_i = 1'b0; jump_addr_i = 32'h1234_5678; ex_busy_i = 1'b0;
        id_rs1_addr_i = 5'd1; id_rs2_addr_i = 5'd2; id_ex_rd_addr_i = 5'd3;
        id_ex_load_i = 1'b0; halt_req_i = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        sample();
        chk("reset_halt_ack", 32'(halt_ack_o), 32'd0);
        chk("reset_stall_cnt", stall_cnt_o, 32'd0);
        advance();
        rst = 1'b0;

        // Jump redirect and flush, then quiet next cycle
        jump_en_i = 1'b1; jump_addr_i = 32'h0000_0040;
        sample();
        chk("jump_addr_40", pc_jump_addr_o, 32'h40);
        chk("jump_en_1", 32'(pc_jump_en_o), 32'd1);
        chk("jump_hold_0", 32'(pc_hold_o), 32'd0);
        advance();
        jump_en_i = 1'b0;
        sample();
        chk("post_jump_flush", 32'({if_id_flush_o, id_ex_flush_o, pc_jump_en_o, pc_hold_o}), 32'd0);
        advance();

        // Busy for 3 cycles
        ex_busy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("busy_holds", 32'({pc_hold_o, if_id_hold_o, id_ex_hold_o}), 32'd7);
            advance();
        end
        ex_busy_i = 1'b0;
        sample();
        chk("busy_stall_cnt", stall_cnt_o, 32'd3);
        advance();
        ex_busy_i = 1'b1; jump_en_i = 1'b1;
        sample();
        chk("busy_jump_wins", 32'({pc_jump_en_o, pc_hold_o, id_ex_hold_o}), 32'b100);
        advance();
        idle_inputs();

        // Load-use on rs2, then rd=0 gives no stall
        id_ex_load_i = 1'b1; id_ex_rd_addr_i = 5'd5; id_rs2_addr_i = 5'd5;
        sample();
        chk("lu_stall", 32'({pc_hold_o, if_id_hold_o, id_ex_flush_o}), 32'd7);
        advance();
        idle_inputs();
        sample();
        chk("lu_one_cycle", 32'(pc_hold_o), 32'd0);
        chk("lu_stall_cnt", stall_cnt_o, 32'd4);
        advance();
        id_ex_load_i = 1'b1; id_ex_rd_addr_i = 5'd0; id_rs1_addr_i = 5'd0;
        sample();
        chk("lu_rd0", 32'(pc_hold_o), 32'd0);
        advance();
        idle_inputs();

        // Halt at cycle 0, ack from cycle 3, drop at cycle 6, run at cycle 7
        halt_req_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c == 6) halt_req_i = 1'b0;
            sample();
            chk("halt_ack_seq", 32'(halt_ack_o), 32'((c >= 3 && c <= 6) ? 1 : 0));
            if (c < 7) chk("halt_pc_hold", 32'(pc_hold_o), 32'd1);
            else chk("resume_ctrl", 32'({pc_hold_o, if_id_hold_o, id_ex_flush_o}), 32'd0);
            advance();
        end

        // Abort: one-cycle request never acks
        halt_req_i = 1'b1;
        sample(); advance();
        halt_req_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            sample();
            chk("abort_no_ack", 32'(halt_ack_o), 32'd0);
            advance();
        end

        // Reset while halted
        halt_req_i = 1'b1;
        for (int c = 0; c < 4; c++) begin sample(); advance(); end
        sample();
        chk("halted_before_rst", 32'(halt_ack_o), 32'd1);
        rst = 1'b1;
        advance();
        rst = 1'b0;
        sample();
        chk("rst_halt_ack", 32'(halt_ack_o), 32'd0);
        chk("rst_stall_cnt", stall_cnt_o, 32'd0);
        advance();
        idle_inputs();
        sample(); advance();

        // Counter wrap from preload
        @(negedge clk);
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        m_stall = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        m_stall = 32'hFFFF_FFFF;
        ex_busy_i = 1'b1;
        sample();
        chk("wrap_preload", stall_cnt_o, 32'hFFFF_FFFF);
        advance();
        ex_busy_i = 1'b0;
        sample();
        chk("wrap_zero", stall_cnt_o, 32'd0);
        advance();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            jump_en_i = ($urandom_range(0, 7) == 0);
            jump_addr_i = $urandom;
            ex_busy_i = ($urandom_range(0, 4) == 0);
            id_ex_load_i = ($urandom_range(0, 2) == 0);
            id_rs1_addr_i = 5'($urandom_range(0, 3));
            id_rs2_addr_i = 5'($urandom_range(0, 3));
            id_ex_rd_addr_i = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) halt_req_i = ~halt_req_i;
            sample();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
